// File: rtl/uart_tx_buf_pkg.sv
// Shared UART definitions: default line settings, frame constants,
// transmit FSM state encoding and a counter-width helper.
package uart_tx_buf_pkg;

    localparam int DEF_CLK_FREQ = 50_000_000;
    localparam int DEF_BAUD     = 115200;
    localparam int DATA_BITS    = 8;
    localparam int STOP_BITS    = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_e;

    // A divider of 1 still needs a 1-bit counter.
    function automatic int cnt_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_buf_if.sv
// Byte-in / serial-out bundle of the buffered UART transmitter.
// master: byte producer (tx_ready/tx_data). slave: transmitter.
interface uart_tx_buf_if;
    import uart_tx_buf_pkg::*;

    logic                 tx_ready;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx;
    logic                 tx_busy;
    logic                 tx_full;
    logic                 overflow;

    modport master (
        output tx_ready, tx_data,
        input  tx, tx_busy, tx_full, overflow
    );

    modport slave (
        input  tx_ready, tx_data,
        output tx, tx_busy, tx_full, overflow
    );

endinterface

// File: rtl/uart_byte_fifo.sv
// Synchronous byte FIFO. Ports: clk, rst (sync, active-high),
// wr_en_i/din_i, rd_en_i/dout_o (show-ahead), count_o, full_o, empty_o, drop_o.
module uart_byte_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en_i,
    input  logic [W-1:0]           din_i,
    input  logic                   rd_en_i,
    output logic [W-1:0]           dout_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic                   drop_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          full_q;
    logic          wr_ok, rd_ok;

    // A write at full still fits when the head leaves on the same edge.
    assign rd_ok  = rd_en_i & (count_q != '0);
    assign wr_ok  = wr_en_i & ((count_q < DEPTH_C) | rd_ok);
    assign drop_o = wr_en_i & ~wr_ok;

    always_comb begin
        count_d = count_q;
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == DEPTH_C);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= din_i;
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = full_q;
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a START/DATA/STOP FSM.
// Ports: clk, rst (sync, active-high), bus (tx_ready/tx_data in; tx, tx_busy, tx_full, overflow out).
module uart_tx_buf
    import uart_tx_buf_pkg::*;
#(
    parameter int CLK_FREQ   = DEF_CLK_FREQ,
    parameter int BAUD       = DEF_BAUD,
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    uart_tx_buf_if.slave bus
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int CNT_W    = cnt_width(BAUD_DIV);
    localparam int BIT_W    = $clog2(DATA_BITS);
    localparam int FCW      = $clog2(FIFO_DEPTH) + 1;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BAUD_DIV - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 ovf_q;

    logic                 pop;
    logic [DATA_BITS-1:0] head;
    logic [FCW-1:0]       fifo_count;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_drop;
    logic                 bit_end;

    uart_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (DATA_BITS)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en_i (bus.tx_ready),
        .din_i   (bus.tx_data),
        .rd_en_i (pop),
        .dout_o  (head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .drop_o  (fifo_drop)
    );

    assign bit_end = (cnt_q == CNT_MAX);

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (!fifo_empty) state_d = ST_START;
            ST_START: if (bit_end) state_d = ST_DATA;
            ST_DATA:  if (bit_end && bit_q == LAST_BIT) state_d = ST_STOP;
            ST_STOP:  if (bit_end) state_d = fifo_empty ? ST_IDLE : ST_START;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath next values; the stop-end pop starts the next frame
    // on the same edge so frames are back-to-back.
    always_comb begin
        pop     = 1'b0;
        cnt_d   = bit_end ? '0 : cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    tx_d    = 1'b0;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    bit_d = '0;
                    tx_d  = shift_q[0];
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_q == LAST_BIT) begin
                        tx_d = 1'b1;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end
            ST_STOP: begin
                if (bit_end && !fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    tx_d    = 1'b0;
                end
            end
            default: begin
                cnt_d = '0;
                tx_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            ovf_q   <= ovf_q | fifo_drop;
        end
    end

    assign bus.tx       = tx_q;
    assign bus.tx_busy  = (state_q != ST_IDLE) | (fifo_count != '0);
    assign bus.tx_full  = fifo_full;
    assign bus.overflow = ovf_q;

endmodule
